// File: rtl/norm_shift_counter.sv
// norm_shift_counter: post-add normalization for the FP adder datapath.
// Loads an un-normalized mantissa and shifts it left one bit per clock
// until its MSB is 1, counting the shifts for the exponent-adjust stage.
// Optional build macro NORM_EXP_ADJUST_EN adds exponent capture and
// adjustment (exp_in_i, exp_out_o, underflow_o).
//
// Handshake: start_i is a request sampled only while idle (busy_o=0);
// it is accepted on that edge and ignored at any other time. done_o is a
// single-cycle completion pulse; mant_out_o/shift_count_o are valid from
// that cycle and held until the next accepted start_i.
module norm_shift_counter #(
    parameter int W  = 24,
    parameter int CW = 5
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          start_i,
    input  logic [W-1:0]  mant_in_i,
`ifdef NORM_EXP_ADJUST_EN
    input  logic [7:0]    exp_in_i,
    output logic [7:0]    exp_out_o,
    output logic          underflow_o,
`endif
    output logic [W-1:0]  mant_out_o,
    output logic [CW-1:0] shift_count_o,
    output logic          zero_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [1:0]    state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  mant_q, mant_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          zero_q, zero_d;

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            mant_q  <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mant_q  <= mant_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
        end
    end

    // Next-state and datapath update; a zero mantissa skips SHIFT since it
    // can never be normalized.
    always_comb begin
        state_d = state_q;
        mant_d  = mant_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    mant_d  = mant_in_i;
                    cnt_d   = '0;
                    zero_d  = (mant_in_i == '0);
                    state_d = (mant_in_i == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (mant_q[W-1]) begin
                    state_d = DONE;
                end else begin
                    mant_d = {mant_q[W-2:0], 1'b0};
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef NORM_EXP_ADJUST_EN
    logic [7:0]  exp_in_q, exp_in_d;
    logic [7:0]  exp_out_q, exp_out_d;
    logic        underflow_q, underflow_d;
    logic [31:0] exp_diff;
    logic        enter_done;

    assign enter_done = (state_d == DONE) && (state_q != DONE);
    assign exp_diff   = 32'(exp_in_q) - 32'(cnt_q);

    // Exponent result is produced on entry to DONE and held afterwards.
    always_comb begin
        exp_in_d    = exp_in_q;
        exp_out_d   = exp_out_q;
        underflow_d = underflow_q;
        if (state_q == IDLE && start_i) begin
            exp_in_d = exp_in_i;
        end
        if (enter_done) begin
            if (state_q == IDLE) begin
                // Zero mantissa: no exponent can represent it.
                exp_out_d   = '0;
                underflow_d = 1'b1;
            end else if (32'(cnt_q) > 32'(exp_in_q)) begin
                exp_out_d   = '0;
                underflow_d = 1'b1;
            end else begin
                exp_out_d   = exp_diff[7:0];
                underflow_d = 1'b0;
            end
        end
    end

    // Exponent registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            exp_in_q    <= '0;
            exp_out_q   <= '0;
            underflow_q <= 1'b0;
        end else begin
            exp_in_q    <= exp_in_d;
            exp_out_q   <= exp_out_d;
            underflow_q <= underflow_d;
        end
    end

    assign exp_out_o   = exp_out_q;
    assign underflow_o = underflow_q;
`endif

    assign mant_out_o    = mant_q;
    assign shift_count_o = cnt_q;
    assign zero_o        = zero_q;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);
    assign state_o       = state_q;

endmodule
